// File: rtl/hash_partitioner.sv
// hash_partitioner: groups hashed tuples into per-partition line buffers and
// emits full lines, then flushes partial lines and an end marker when the
// stream ends.
module hash_partitioner #(
  parameter int NUM_PARTITIONS  = 16,
  parameter int TUPLES_PER_LINE = 8,
  parameter int PART_SHIFT      = 0,
  parameter int HASH_BITS       = 32,
  localparam int PW = $clog2(NUM_PARTITIONS),
  localparam int SW = $clog2(TUPLES_PER_LINE),
  localparam int CW = SW + 1,
  localparam int LW = 64 * TUPLES_PER_LINE
) (
  input  logic          clk,
  input  logic          resetn,
  output logic          in_ready,
  input  logic          in_valid,
  input  logic [95:0]   in_data,
  input  logic          in_last_processed,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [LW-1:0] out_data,
  output logic [PW-1:0] out_partition,
  output logic [CW-1:0] out_count,
  output logic          out_last
);

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_END} state_t;

  state_t        state;
  logic [PW-1:0] idx;
  logic [63:0]   line_buf [NUM_PARTITIONS][TUPLES_PER_LINE];
  logic [CW-1:0] fill     [NUM_PARTITIONS];

  logic          free;
  logic          accept;
  logic [PW-1:0] part;
  logic [63:0]   tuple;
  logic [LW-1:0] full_line;
  logic [LW-1:0] flush_line;

  // Hash bits above the partition field carry no meaning here.
  logic unused_hash;
  assign unused_hash = ^in_data[64 +: HASH_BITS];

  assign free     = ~out_valid | out_ready;
  assign part     = in_data[64 + PART_SHIFT +: PW];
  assign tuple    = in_data[63:0];
  assign in_ready = resetn & (state == ST_RUN) & free;
  assign accept   = in_valid & in_ready;

  // Line images: the completing line with the incoming tuple merged in, and
  // the flush line with slots beyond the fill level forced to zero.
  always_comb begin
    full_line  = '0;
    flush_line = '0;
    for (int i = 0; i < TUPLES_PER_LINE; i++) begin
      full_line[64*i +: 64]  = (SW'(i) == fill[part][SW-1:0]) ? tuple : line_buf[part][i];
      flush_line[64*i +: 64] = (CW'(i) < fill[idx]) ? line_buf[idx][i] : 64'd0;
    end
  end

  // Control FSM, line buffers and the single-entry output register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= ST_RUN;
      idx           <= '0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      out_data      <= '0;
      out_partition <= '0;
      out_count     <= '0;
      for (int p = 0; p < NUM_PARTITIONS; p++) begin
        fill[p] <= '0;
        for (int s = 0; s < TUPLES_PER_LINE; s++) line_buf[p][s] <= '0;
      end
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      case (state)
        ST_RUN: begin
          if (accept) begin
            line_buf[part][fill[part][SW-1:0]] <= tuple;
            if (fill[part] == CW'(TUPLES_PER_LINE - 1)) begin
              out_valid     <= 1'b1;
              out_last      <= 1'b0;
              out_data      <= full_line;
              out_count     <= CW'(TUPLES_PER_LINE);
              out_partition <= part;
              fill[part]    <= '0;
            end else begin
              fill[part] <= fill[part] + 1'b1;
            end
            if (in_last_processed) begin
              state <= ST_FLUSH;
              idx   <= '0;
            end
          end
        end
        ST_FLUSH: begin
          if (free) begin
            if (fill[idx] != '0) begin
              out_valid     <= 1'b1;
              out_last      <= 1'b0;
              out_data      <= flush_line;
              out_count     <= fill[idx];
              out_partition <= idx;
              fill[idx]     <= '0;
            end
            if (idx == PW'(NUM_PARTITIONS - 1)) state <= ST_END;
            else                                idx   <= idx + 1'b1;
          end
        end
        ST_END: begin
          if (free) begin
            out_valid     <= 1'b1;
            out_last      <= 1'b1;
            out_data      <= '0;
            out_count     <= '0;
            out_partition <= '0;
            state         <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_partitioner.sv
// Testbench for hash_partitioner: a bench-side model predicts every output
// beat into a queue; a monitor pops and compares on each handshake.
module tb_hash_partitioner;

  localparam int N = 16;
  localparam int T = 8;

  logic         clk = 1'b0;
  logic         resetn;
  logic         in_ready;
  logic         in_valid;
  logic [95:0]  in_data;
  logic         in_last_processed;
  logic         out_ready;
  logic         out_valid;
  logic [511:0] out_data;
  logic [3:0]   out_partition;
  logic [3:0]   out_count;
  logic         out_last;

  always #5 clk = ~clk;

  hash_partitioner #(
    .NUM_PARTITIONS(N), .TUPLES_PER_LINE(T), .PART_SHIFT(0), .HASH_BITS(32)
  ) dut (
    .clk(clk), .resetn(resetn),
    .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
    .in_last_processed(in_last_processed),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_partition(out_partition), .out_count(out_count), .out_last(out_last)
  );

  typedef struct {
    logic [3:0]   part;
    logic [3:0]   cnt;
    logic [511:0] data;
    logic         last;
  } beat_t;

  beat_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] m_buf [N][T];
  int          m_fill [N];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input int p, input int cnt, input logic last);
    beat_t b;
    b.data = '0;
    for (int s = 0; s < cnt; s++) b.data[64*s +: 64] = m_buf[p][s];
    b.part = 4'(p);
    b.cnt  = 4'(cnt);
    b.last = last;
    exp_q.push_back(b);
  endtask

  task automatic model_accept(input logic [31:0] h, input logic [31:0] pl,
                              input logic [31:0] k, input logic last);
    int p;
    p = int'(h[3:0]);
    m_buf[p][m_fill[p]] = {pl, k};
    m_fill[p]++;
    if (m_fill[p] == T) begin
      push_beat(p, T, 1'b0);
      m_fill[p] = 0;
    end
    if (last) begin
      for (int i = 0; i < N; i++) begin
        if (m_fill[i] > 0) push_beat(i, m_fill[i], 1'b0);
        m_fill[i] = 0;
      end
      push_beat(0, 0, 1'b1);
    end
  endtask

  task automatic send_tuple(input logic [31:0] h, input logic [31:0] pl,
                            input logic [31:0] k, input logic last);
    bit done;
    done = 0;
    in_data           = {h, pl, k};
    in_last_processed = last;
    in_valid          = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
    end
    #1;
    in_valid          = 1'b0;
    in_last_processed = 1'b0;
    if (done) model_accept(h, pl, k, last);
    else begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready never rose for key=%h, required accept", k);
    end
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) ok = 1;
    end
    @(posedge clk); #1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain: %0d expected beats still outstanding, required 0", exp_q.size());
    end
  endtask

  // Scoreboard monitor: every handshaken beat must match the next prediction.
  always @(negedge clk) begin
    beat_t e;
    if (resetn && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got part=%0d cnt=%0d last=%0b, required no beat",
                 out_partition, out_count, out_last);
      end else begin
        e = exp_q.pop_front();
        if (out_partition !== e.part || out_count !== e.cnt ||
            out_last !== e.last || out_data !== e.data) begin
          errors++;
          $display("FAIL beat: got part=%0d cnt=%0d last=%0b data=%h, required part=%0d cnt=%0d last=%0b data=%h",
                   out_partition, out_count, out_last, out_data, e.part, e.cnt, e.last, e.data);
        end
      end
    end
  end

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b0; in_data = '0; in_last_processed = 1'b0; out_ready = 1'b1;
    step(3);
    checks++;
    if ({out_valid, out_last, out_count, out_partition, in_ready} !== 11'd0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_state: got valid=%0b last=%0b cnt=%0d part=%0d in_ready=%0b, required all 0",
               out_valid, out_last, out_count, out_partition, in_ready);
    end
    resetn = 1'b1;
    step(1);
  endtask

  task automatic test_partition_fill();
    for (int k = 1; k <= 8; k++) begin
      send_tuple(32'h3, 32'(k + 'h100), 32'(k), 1'b0);
      if (k == 7) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL fill_early: got out_valid=%0b after 7 tuples, required 0", out_valid);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b1 || out_partition !== 4'd3 || out_count !== 4'd8) begin
      errors++;
      $display("FAIL fill_latency: got valid=%0b part=%0d cnt=%0d, required 1/3/8",
               out_valid, out_partition, out_count);
    end
    wait_drain();
  endtask

  task automatic test_alternating();
    for (int i = 0; i < 16; i++) begin
      send_tuple((i % 2 == 1) ? 32'hF : 32'h0, 32'(i + 'h500), 32'(i + 'h200), 1'b0);
      if (i >= 14) begin
        checks++;
        if (out_valid !== 1'b1 || out_partition !== ((i == 14) ? 4'd0 : 4'd15)) begin
          errors++;
          $display("FAIL alt_beat: accept %0d got valid=%0b part=%0d, required 1/%0d",
                   i + 1, out_valid, out_partition, (i == 14) ? 0 : 15);
        end
      end
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) send_tuple(32'h6, 32'(k + 'h600), 32'(k + 'h60), 1'b0);
    in_data = {32'h6, 32'h699, 32'h99}; in_last_processed = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_partition !== 4'd6 ||
          out_count !== 4'd8 || exp_q.size() == 0 || out_data !== exp_q[0].data) begin
        errors++;
        $display("FAIL bp_hold: got in_ready=%0b valid=%0b part=%0d cnt=%0d, required 0/1/6/8 with stable data",
                 in_ready, out_valid, out_partition, out_count);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain: got in_ready=%0b in drain cycle, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_accept(32'h6, 32'h699, 32'h99, 1'b0);
    for (int k = 0; k < 7; k++) send_tuple(32'h6, 32'(k + 'h6A0), 32'(k + 'hA0), 1'b0);
    wait_drain();
  endtask

  task automatic test_flush();
    bit seen;
    seen = 0;
    for (int k = 0; k < 3; k++) send_tuple(32'h2, 32'(k + 'h220), 32'(k + 'h21), 1'b0);
    send_tuple(32'h5, 32'h550, 32'h51, 1'b1);
    for (int c = 0; c < 40 && !seen; c++) begin
      if (c > 0) @(negedge clk);
      else @(negedge clk);
      if (out_valid && out_last) seen = 1;
      else begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL flush_in_ready: got in_ready=%0b during flush, required 0", in_ready);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL flush_marker: got no marker within 40 cycles, required marker");
    end
    wait_drain();
  endtask

  task automatic test_last_completes();
    int  gap;
    bit  seen;
    gap = 0; seen = 0;
    for (int k = 0; k < 7; k++) send_tuple(32'h7, 32'(k + 'h770), 32'(k + 'h71), 1'b0);
    send_tuple(32'h7, 32'h777, 32'h77, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_count !== 4'd8 || out_last !== 1'b0 || out_partition !== 4'd7) begin
      errors++;
      $display("FAIL last_full: got valid=%0b part=%0d cnt=%0d last=%0b, required 1/7/8/0",
               out_valid, out_partition, out_count, out_last);
    end
    @(negedge clk);
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
      else gap++;
    end
    checks++;
    if (gap != 16 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL last_scan: got gap=%0d last=%0b, required gap=16 last=1", gap, out_last);
    end
    wait_drain();
  endtask

  task automatic test_reset_midflush();
    out_ready = 1'b0;
    send_tuple(32'h1, 32'h310, 32'h31, 1'b0);
    send_tuple(32'h4, 32'h410, 32'h41, 1'b1);
    step(4);
    checks++;
    if (out_valid !== 1'b1 || out_partition !== 4'd1) begin
      errors++;
      $display("FAIL mid_flush_pending: got valid=%0b part=%0d, required 1/1", out_valid, out_partition);
    end
    resetn = 1'b0;
    exp_q.delete();
    for (int i = 0; i < N; i++) m_fill[i] = 0;
    step(2);
    checks++;
    if ({out_valid, out_last, out_count, out_partition, in_ready} !== 11'd0 || out_data !== '0) begin
      errors++;
      $display("FAIL mid_reset_state: got valid=%0b last=%0b cnt=%0d part=%0d in_ready=%0b, required all 0",
               out_valid, out_last, out_count, out_partition, in_ready);
    end
    resetn = 1'b1;
    out_ready = 1'b1;
    step(3);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stale_beat: got out_valid=%0b after reset release, required 0", out_valid);
    end
    for (int k = 0; k < 8; k++) send_tuple(32'h1, 32'(k + 'h1100), 32'(k + 'h11), 1'b0);
    wait_drain();
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_fill[i] = 0;
    test_reset();
    test_partition_fill();
    test_alternating();
    test_backpressure();
    test_flush();
    test_last_completes();
    test_reset_midflush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
